// File: rtl/seq_window_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_window_checker_if
//  Description : Signal bundle between a monitored design and the
//                seq_window_checker assertion monitor.
//                master : drives trig/resp/dis/clr and observes results
//                slave  : the checker; samples stimulus, drives results
//  Signals     : trig[NCH]      per-channel antecedent
//                resp[NCH]      per-channel consequent
//                dis[NCH]       per-channel abort of all attempts
//                clr            clears sticky fail, first channel, counters
//                pass_pulse     1-cycle pulse per channel, >=1 attempt passed
//                fail_pulse     1-cycle pulse per channel, >=1 attempt failed
//                fail_sticky    set on any failure until clr/reset
//                first_fail_ch  lowest channel of the first failing cycle
//                pass_cnt       saturating total of passed attempts
//                fail_cnt       saturating total of failed attempts
//  Revision    : 1.0  initial release
// ============================================================================
interface seq_window_checker_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16,
  parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
);
  logic [NCH-1:0]   trig;
  logic [NCH-1:0]   resp;
  logic [NCH-1:0]   dis;
  logic             clr;
  logic [NCH-1:0]   pass_pulse;
  logic [NCH-1:0]   fail_pulse;
  logic             fail_sticky;
  logic [CH_W-1:0]  first_fail_ch;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;

  modport master (
    output trig, resp, dis, clr,
    input  pass_pulse, fail_pulse, fail_sticky, first_fail_ch, pass_cnt, fail_cnt
  );

  modport slave (
    input  trig, resp, dis, clr,
    output pass_pulse, fail_pulse, fail_sticky, first_fail_ch, pass_cnt, fail_cnt
  );
endinterface
`default_nettype wire

// File: rtl/seq_window_checker.sv
`default_nettype none
// ============================================================================
//  Module      : seq_window_checker
//  Description : Multi-channel on-chip monitor for the property
//                  disable iff (dis) trig[*REP] |-> ##[MIN_DLY:MAX_DLY] resp
//                (MODE=0) or its negation (MODE=1). Overlapping attempts
//                are tracked per channel in an age-indexed pending vector.
//  Ports       : clk    clock, all logic on the rising edge
//                rst_n  synchronous reset, active low
//                bus    seq_window_checker_if.slave (stimulus in, results out)
//  Parameters  : NCH (1..32), REP (1..15), MIN_DLY (1..MAX_DLY),
//                MAX_DLY (MIN_DLY..16), MODE (0/1), CNT_W counter width
//  Revision    : 1.0  initial release
// ============================================================================
module seq_window_checker #(
  parameter int NCH     = 4,
  parameter int REP     = 1,
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 3,
  parameter int MODE    = 0,
  parameter int CNT_W   = 16
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  seq_window_checker_if.slave bus
);

  localparam int c_ch_w  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int c_run_w = $clog2(REP + 1);
  // per-channel count of attempts resolved in one cycle (at most MAX_DLY)
  localparam int c_pc_w  = $clog2(MAX_DLY + 1);
  // sum over all channels in one cycle
  localparam int c_tot_w = $clog2(NCH * MAX_DLY + 1);
  // accumulator one bit wider than either operand so saturation is exact
  localparam int c_acc_w = ((CNT_W > c_tot_w) ? CNT_W : c_tot_w) + 1;
  localparam logic [c_acc_w-1:0] c_cnt_max = c_acc_w'({CNT_W{1'b1}});

  // per-channel resolved-attempt counts, already mapped to pass/fail by MODE
  logic [c_pc_w-1:0] w_ch_pass [NCH];
  logic [c_pc_w-1:0] w_ch_fail [NCH];

  // --------------------------------------------------------------------------
  // Per-channel attempt tracking
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [c_run_w-1:0] r_run;       // consecutive trig cycles, saturates at REP
    logic [MAX_DLY:1]   r_pend;      // bit k: attempt matched k cycles ago
    logic [c_run_w-1:0] w_run_nxt;
    logic [MAX_DLY:1]   w_pend_nxt;
    logic [MAX_DLY:1]   w_hit;       // resolved by resp inside the window
    logic [MAX_DLY:1]   w_miss;      // reached window end without resp
    logic               w_match;
    logic [c_pc_w-1:0]  w_n_hit;
    logic [c_pc_w-1:0]  w_n_miss;

    always_comb begin
      w_hit      = '0;
      w_miss     = '0;
      w_pend_nxt = '0;
      w_run_nxt  = '0;
      w_match    = 1'b0;
      w_n_hit    = '0;
      w_n_miss   = '0;

      // One resp resolves every attempt that is old enough; attempts younger
      // than MIN_DLY ignore resp and keep ageing.
      for (int k = 1; k <= MAX_DLY; k++) begin
        if (r_pend[k]) begin
          if (bus.resp[gi] && (k >= MIN_DLY)) begin
            w_hit[k] = 1'b1;
          end else if (k == MAX_DLY) begin
            w_miss[k] = 1'b1;
          end
        end
      end

      // The match uses the current trig, so it fires when the stored run
      // is already REP-1 (or saturated at REP for a held trig).
      w_match = bus.trig[gi] && (r_run >= c_run_w'(REP - 1));
      if (bus.trig[gi]) begin
        w_run_nxt = (r_run == c_run_w'(REP)) ? r_run : r_run + c_run_w'(1);
      end

      // Unresolved attempts age by one; a new match enters at age 1.
      w_pend_nxt[1] = w_match;
      for (int k = 2; k <= MAX_DLY; k++) begin
        w_pend_nxt[k] = r_pend[k-1] & ~w_hit[k-1] & ~w_miss[k-1];
      end

      // Disable aborts everything on this channel, including this cycle's
      // resolutions and any match formed in this cycle.
      if (bus.dis[gi]) begin
        w_hit      = '0;
        w_miss     = '0;
        w_pend_nxt = '0;
        w_run_nxt  = '0;
      end

      for (int k = 1; k <= MAX_DLY; k++) begin
        w_n_hit  = w_n_hit  + c_pc_w'(w_hit[k]);
        w_n_miss = w_n_miss + c_pc_w'(w_miss[k]);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_run  <= '0;
        r_pend <= '0;
      end else begin
        r_run  <= w_run_nxt;
        r_pend <= w_pend_nxt;
      end
    end

    // In the negated form a resp inside the window is the failure.
    assign w_ch_pass[gi] = (MODE == 0) ? w_n_hit  : w_n_miss;
    assign w_ch_fail[gi] = (MODE == 0) ? w_n_miss : w_n_hit;
  end

  // --------------------------------------------------------------------------
  // Cross-channel aggregation
  // --------------------------------------------------------------------------
  logic [NCH-1:0]     w_pass_vec;
  logic [NCH-1:0]     w_fail_vec;
  logic [c_tot_w-1:0] w_tot_pass;
  logic [c_tot_w-1:0] w_tot_fail;
  logic [c_ch_w-1:0]  w_low_fail;
  logic [c_acc_w-1:0] w_pass_sum;
  logic [c_acc_w-1:0] w_fail_sum;

  always_comb begin
    w_pass_vec = '0;
    w_fail_vec = '0;
    w_tot_pass = '0;
    w_tot_fail = '0;
    w_low_fail = '0;
    w_pass_sum = '0;
    w_fail_sum = '0;

    for (int i = 0; i < NCH; i++) begin
      w_pass_vec[i] = |w_ch_pass[i];
      w_fail_vec[i] = |w_ch_fail[i];
      w_tot_pass    = w_tot_pass + c_tot_w'(w_ch_pass[i]);
      w_tot_fail    = w_tot_fail + c_tot_w'(w_ch_fail[i]);
    end

    // Scan downwards so the last assignment is the lowest failing channel.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_fail_vec[i]) begin
        w_low_fail = c_ch_w'(i);
      end
    end

    w_pass_sum = c_acc_w'(bus.pass_cnt) + c_acc_w'(w_tot_pass);
    w_fail_sum = c_acc_w'(bus.fail_cnt) + c_acc_w'(w_tot_fail);
    if (w_pass_sum > c_cnt_max) begin
      w_pass_sum = c_cnt_max;
    end
    if (w_fail_sum > c_cnt_max) begin
      w_fail_sum = c_cnt_max;
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs
  // --------------------------------------------------------------------------
  logic [NCH-1:0]    r_pass_pulse;
  logic [NCH-1:0]    r_fail_pulse;
  logic              r_fail_sticky;
  logic [c_ch_w-1:0] r_first_fail_ch;
  logic [CNT_W-1:0]  r_pass_cnt;
  logic [CNT_W-1:0]  r_fail_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pass_pulse    <= '0;
      r_fail_pulse    <= '0;
      r_fail_sticky   <= 1'b0;
      r_first_fail_ch <= '0;
      r_pass_cnt      <= '0;
      r_fail_cnt      <= '0;
    end else begin
      // Pulses are never suppressed by clr.
      r_pass_pulse <= w_pass_vec;
      r_fail_pulse <= w_fail_vec;
      if (bus.clr) begin
        // clr takes priority: a failure in the same cycle is not recorded.
        r_fail_sticky   <= 1'b0;
        r_first_fail_ch <= '0;
        r_pass_cnt      <= '0;
        r_fail_cnt      <= '0;
      end else begin
        if ((|w_fail_vec) && !r_fail_sticky) begin
          r_fail_sticky   <= 1'b1;
          r_first_fail_ch <= w_low_fail;
        end
        r_pass_cnt <= w_pass_sum[CNT_W-1:0];
        r_fail_cnt <= w_fail_sum[CNT_W-1:0];
      end
    end
  end

  assign bus.pass_pulse    = r_pass_pulse;
  assign bus.fail_pulse    = r_fail_pulse;
  assign bus.fail_sticky   = r_fail_sticky;
  assign bus.first_fail_ch = r_first_fail_ch;
  assign bus.pass_cnt      = r_pass_cnt;
  assign bus.fail_cnt      = r_fail_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_window_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_window_checker
//  Description : Drives three differently configured seq_window_checker
//                instances with the same stimulus. A reference model keeps
//                each attempt as its match cycle and resolves it by age;
//                expected per-cycle outputs are queued and a separate
//                monitor compares them against the DUT outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_window_checker;

  localparam int NCH = 4;
  localparam int ND  = 3;

  // Configurations:  D0 REP2 MIN1 MAX3 MODE0 CNT_W16
  //                  D1 REP1 MIN2 MAX3 MODE0 CNT_W2
  //                  D2 REP3 MIN2 MAX4 MODE1 CNT_W8
  function automatic int rep_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 3;
  endfunction
  function automatic int min_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction
  function automatic int max_of(input int d);
    return (d == 2) ? 4 : 3;
  endfunction
  function automatic int mode_of(input int d);
    return (d == 2) ? 1 : 0;
  endfunction
  function automatic int cmax_of(input int d);
    return (d == 0) ? 65535 : (d == 1) ? 3 : 255;
  endfunction

  logic clk;
  logic rst_n;

  seq_window_checker_if #(.NCH(NCH), .CNT_W(16)) bus0 ();
  seq_window_checker_if #(.NCH(NCH), .CNT_W(2))  bus1 ();
  seq_window_checker_if #(.NCH(NCH), .CNT_W(8))  bus2 ();

  seq_window_checker #(.NCH(NCH), .REP(2), .MIN_DLY(1), .MAX_DLY(3), .MODE(0), .CNT_W(16))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  seq_window_checker #(.NCH(NCH), .REP(1), .MIN_DLY(2), .MAX_DLY(3), .MODE(0), .CNT_W(2))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  seq_window_checker #(.NCH(NCH), .REP(3), .MIN_DLY(2), .MAX_DLY(4), .MODE(1), .CNT_W(8))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] pp;
    logic [NCH-1:0] fp;
    logic           st;
    logic [31:0]    ffc;
    logic [31:0]    pc;
    logic [31:0]    fc;
  } exp_t;

  exp_t expq [ND][$];

  // Reference model state
  int att      [ND][NCH][$];  // match cycles of outstanding attempts
  int last_brk [ND][NCH];     // last cycle with trig low, dis high or reset
  int m_pc     [ND];
  int m_fc     [ND];
  bit m_st     [ND];
  int m_ffc    [ND];
  int cyc;

  int n_checks;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Apply the property rules to one cycle of inputs and queue what every
  // DUT should show after the next rising edge.
  task automatic model_step(input logic [NCH-1:0] t, input logic [NCH-1:0] r,
                            input logic [NCH-1:0] ds, input logic c, input logic rn);
    for (int d = 0; d < ND; d++) begin
      exp_t e;
      int   tp;
      int   tf;
      int   lowest;
      e.pp = '0;
      e.fp = '0;
      tp = 0;
      tf = 0;
      lowest = -1;
      if (!rn) begin
        for (int ch = 0; ch < NCH; ch++) begin
          att[d][ch].delete();
          last_brk[d][ch] = cyc;
        end
        m_pc[d]  = 0;
        m_fc[d]  = 0;
        m_st[d]  = 1'b0;
        m_ffc[d] = 0;
      end else begin
        for (int ch = 0; ch < NCH; ch++) begin
          int np;
          int nf;
          int keep[$];
          np = 0;
          nf = 0;
          keep.delete();
          if (ds[ch]) begin
            att[d][ch].delete();
            last_brk[d][ch] = cyc;
          end else begin
            for (int i = 0; i < att[d][ch].size(); i++) begin
              int age;
              age = cyc - att[d][ch][i];
              if (r[ch] && age >= min_of(d) && age <= max_of(d)) begin
                if (mode_of(d) == 0) np++; else nf++;
              end else if (age == max_of(d)) begin
                if (mode_of(d) == 0) nf++; else np++;
              end else begin
                keep.push_back(att[d][ch][i]);
              end
            end
            if (!t[ch]) begin
              last_brk[d][ch] = cyc;
            end else if (cyc - last_brk[d][ch] >= rep_of(d)) begin
              keep.push_back(cyc);
            end
            att[d][ch] = keep;
          end
          e.pp[ch] = (np > 0);
          e.fp[ch] = (nf > 0);
          tp += np;
          tf += nf;
          if (nf > 0 && lowest < 0) lowest = ch;
        end
        if (c) begin
          m_st[d]  = 1'b0;
          m_ffc[d] = 0;
          m_pc[d]  = 0;
          m_fc[d]  = 0;
        end else begin
          if (lowest >= 0 && !m_st[d]) begin
            m_st[d]  = 1'b1;
            m_ffc[d] = lowest;
          end
          m_pc[d] = (m_pc[d] + tp > cmax_of(d)) ? cmax_of(d) : m_pc[d] + tp;
          m_fc[d] = (m_fc[d] + tf > cmax_of(d)) ? cmax_of(d) : m_fc[d] + tf;
        end
      end
      e.st  = m_st[d];
      e.ffc = m_ffc[d];
      e.pc  = m_pc[d];
      e.fc  = m_fc[d];
      expq[d].push_back(e);
    end
  endtask

  task automatic step(input logic [NCH-1:0] t, input logic [NCH-1:0] r,
                      input logic [NCH-1:0] ds, input logic c, input logic rn);
    @(negedge clk);
    rst_n     = rn;
    bus0.trig = t;  bus0.resp = r;  bus0.dis = ds;  bus0.clr = c;
    bus1.trig = t;  bus1.resp = r;  bus1.dis = ds;  bus1.clr = c;
    bus2.trig = t;  bus2.resp = r;  bus2.dis = ds;  bus2.clr = c;
    model_step(t, r, ds, c, rn);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic mon_dut(input int d, input logic [NCH-1:0] pp, input logic [NCH-1:0] fp,
                         input logic st, input logic [31:0] ffc,
                         input logic [31:0] pc, input logic [31:0] fc);
    exp_t e;
    if (expq[d].size() == 0) return;
    e = expq[d].pop_front();
    chk($sformatf("d%0d pass_pulse", d), 32'(pp), 32'(e.pp));
    chk($sformatf("d%0d fail_pulse", d), 32'(fp), 32'(e.fp));
    chk($sformatf("d%0d fail_sticky", d), 32'(st), 32'(e.st));
    chk($sformatf("d%0d first_fail_ch", d), ffc, e.ffc);
    chk($sformatf("d%0d pass_cnt", d), pc, e.pc);
    chk($sformatf("d%0d fail_cnt", d), fc, e.fc);
  endtask

  // Monitor: one expected entry per DUT per clock, checked after the edge.
  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      mon_dut(0, bus0.pass_pulse, bus0.fail_pulse, bus0.fail_sticky,
              32'(bus0.first_fail_ch), 32'(bus0.pass_cnt), 32'(bus0.fail_cnt));
      mon_dut(1, bus1.pass_pulse, bus1.fail_pulse, bus1.fail_sticky,
              32'(bus1.first_fail_ch), 32'(bus1.pass_cnt), 32'(bus1.fail_cnt));
      mon_dut(2, bus2.pass_pulse, bus2.fail_pulse, bus2.fail_sticky,
              32'(bus2.first_fail_ch), 32'(bus2.pass_cnt), 32'(bus2.fail_cnt));
    end
  end

  initial begin : stimulus
    logic [NCH-1:0] t;
    logic [NCH-1:0] r;
    logic [NCH-1:0] ds;
    logic           c;
    logic           rn;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    bus0.trig = '0; bus0.resp = '0; bus0.dis = '0; bus0.clr = 1'b0;
    bus1.trig = '0; bus1.resp = '0; bus1.dis = '0; bus1.clr = 1'b0;
    bus2.trig = '0; bus2.resp = '0; bus2.dis = '0; bus2.clr = 1'b0;

    // reset
    for (int i = 0; i < 3; i++) step('0, '0, '0, 1'b0, 1'b0);
    chk("reset pass_cnt", 32'(bus0.pass_cnt), 32'd0);
    chk("reset fail_cnt", 32'(bus0.fail_cnt), 32'd0);
    chk("reset sticky", 32'(bus0.fail_sticky), 32'd0);
    chk("reset pulses", 32'({bus0.pass_pulse, bus0.fail_pulse}), 32'd0);

    // T1: trig ch0 two cycles, resp two cycles after the match
    step(4'b0001, '0, '0, 1'b0, 1'b1);
    step(4'b0001, '0, '0, 1'b0, 1'b1);
    idle(1);
    step('0, 4'b0001, '0, 1'b0, 1'b1);
    idle(4);
    chk("T1 pass_cnt", 32'(bus0.pass_cnt), 32'd1);
    chk("T1 fail_cnt", 32'(bus0.fail_cnt), 32'd0);

    // T2: same antecedent, no resp
    step(4'b0001, '0, '0, 1'b0, 1'b1);
    step(4'b0001, '0, '0, 1'b0, 1'b1);
    idle(6);
    chk("T2 fail_cnt", 32'(bus0.fail_cnt), 32'd1);
    chk("T2 sticky", 32'(bus0.fail_sticky), 32'd1);
    chk("T2 first_fail_ch", 32'(bus0.first_fail_ch), 32'd0);

    // T3: held trig, overlapping attempts resolved by a single resp
    for (int i = 0; i < 3; i++) step(4'b0001, '0, '0, 1'b0, 1'b1);
    step('0, 4'b0001, '0, 1'b0, 1'b1);
    idle(4);
    chk("T3 pass_cnt", 32'(bus0.pass_cnt), 32'd3);

    // T4: resp too early for MIN_DLY=2 on D1
    step(4'b0001, '0, '0, 1'b0, 1'b1);
    step('0, 4'b0001, '0, 1'b0, 1'b1);
    idle(5);

    // T5: clr, then dis on ch1 while ch2/ch3 fail together
    step('0, '0, '0, 1'b1, 1'b1);
    step(4'b1110, '0, '0, 1'b0, 1'b1);
    step(4'b1110, '0, '0, 1'b0, 1'b1);
    step('0, '0, 4'b0010, 1'b0, 1'b1);
    idle(6);
    chk("T5 first_fail_ch", 32'(bus0.first_fail_ch), 32'd2);
    chk("T5 fail_cnt", 32'(bus0.fail_cnt), 32'd2);
    chk("T5 pass_cnt after clr", 32'(bus0.pass_cnt), 32'd0);
    step('0, '0, '0, 1'b1, 1'b1);
    idle(1);
    chk("T5 sticky cleared", 32'(bus0.fail_sticky), 32'd0);
    chk("T5 fail_cnt cleared", 32'(bus0.fail_cnt), 32'd0);

    // T6: reset in the middle of an attempt
    step(4'b1111, '0, '0, 1'b0, 1'b1);
    step(4'b1111, '0, '0, 1'b0, 1'b1);
    step('0, '0, '0, 1'b0, 1'b0);
    idle(5);
    chk("T6 fail_cnt after reset", 32'(bus0.fail_cnt), 32'd0);
    chk("T6 sticky after reset", 32'(bus0.fail_sticky), 32'd0);

    // Saturation: twelve failures on D1 with a 2-bit counter
    for (int i = 0; i < 3; i++) step(4'b1111, '0, '0, 1'b0, 1'b1);
    idle(6);
    chk("sat fail_cnt", 32'(bus1.fail_cnt), 32'd3);

    // Negated form on D2: resp inside the window on ch3 is a failure
    for (int i = 0; i < 3; i++) step(4'b1000, '0, '0, 1'b0, 1'b1);
    idle(1);
    step('0, 4'b1000, '0, 1'b0, 1'b1);
    idle(5);
    chk("mode1 fail_cnt", 32'(bus2.fail_cnt), 32'd1);
    chk("mode1 sticky", 32'(bus2.fail_sticky), 32'd1);
    chk("mode1 first_fail_ch", 32'(bus2.first_fail_ch), 32'd3);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        t[ch]  = ($urandom_range(0, 99) < 60);
        r[ch]  = ($urandom_range(0, 99) < 25);
        ds[ch] = ($urandom_range(0, 99) < 3);
      end
      c  = ($urandom_range(0, 99) < 2);
      rn = ($urandom_range(0, 999) >= 5);
      step(t, r, ds, c, rn);
    end

    idle(6);
    repeat (2) @(posedge clk);
    #2;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("d%0d queue drained", d), 32'(expq[d].size()), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
